// File: rtl/hazard_control_unit_pkg.sv
// ============================================================================
// Module  : hazard_control_unit_pkg
// Brief   : FSM state encoding and stall-depth constants for the hazard unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STALL  = 2'b01,
        HALTED = 2'b10
    } hcu_state_t;

    localparam int LOAD_USE_STALLS = 1;
    localparam int BR_IDEX_STALLS  = 2;
    localparam int BR_EXMEM_STALLS = 1;
    localparam int FLAG_STALLS     = 1;

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_detect.sv
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational required-stall-count (N) from register/flag fields.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_detect
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int STALL_CNT_W = 2
) (
    input  logic [REG_ADDR_W-1:0]  if_id_rs,
    input  logic [REG_ADDR_W-1:0]  if_id_rt,
    input  logic                   if_id_uses_rt,
    input  logic                   if_id_is_store,
    input  logic                   if_id_branch,
    input  logic                   if_id_cond_branch,
    input  logic [REG_ADDR_W-1:0]  id_ex_rd,
    input  logic                   id_ex_write_reg,
    input  logic                   id_ex_mem_read,
    input  logic                   id_ex_sets_flags,
    input  logic [REG_ADDR_W-1:0]  ex_mem_rd,
    input  logic                   ex_mem_write_reg,
    output logic [STALL_CNT_W-1:0] stall_n
);

    localparam logic [STALL_CNT_W-1:0] c_LU    = STALL_CNT_W'(LOAD_USE_STALLS);
    localparam logic [STALL_CNT_W-1:0] c_BR_EX = STALL_CNT_W'(BR_IDEX_STALLS);
    localparam logic [STALL_CNT_W-1:0] c_BR_MM = STALL_CNT_W'(BR_EXMEM_STALLS);
    localparam logic [STALL_CNT_W-1:0] c_FLAG  = STALL_CNT_W'(FLAG_STALLS);

    function automatic logic reg_match(input logic we,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] src);
        return we && (rd != '0) && (rd == src);
    endfunction

    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;
    logic w_flag;

    // A store's Rt is only needed in MEM, where MEM-MEM forwarding supplies it.
    assign w_load_use = id_ex_mem_read &&
                        (reg_match(id_ex_write_reg, id_ex_rd, if_id_rs) ||
                         (if_id_uses_rt && !if_id_is_store &&
                          reg_match(id_ex_write_reg, id_ex_rd, if_id_rt)));
    assign w_br_ex    = if_id_branch && reg_match(id_ex_write_reg, id_ex_rd, if_id_rs);
    assign w_br_mem   = if_id_branch && reg_match(ex_mem_write_reg, ex_mem_rd, if_id_rs);
    assign w_flag     = if_id_cond_branch && id_ex_sets_flags;

    // Overlapping hazards share stall cycles, so take the maximum.
    always_comb begin
        stall_n = '0;
        if (w_load_use && (c_LU > stall_n))    stall_n = c_LU;
        if (w_br_ex    && (c_BR_EX > stall_n)) stall_n = c_BR_EX;
        if (w_br_mem   && (c_BR_MM > stall_n)) stall_n = c_BR_MM;
        if (w_flag     && (c_FLAG > stall_n))  stall_n = c_FLAG;
    end

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module  : hazard_control_unit
// Brief   : Decode-stage stall/flush/halt controller. Optional perf counters
//           enabled by defining HAZARD_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int STALL_CNT_W = 2
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  if_id_is_store,
    input  logic                  if_id_branch,
    input  logic                  if_id_cond_branch,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_write_reg,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_sets_flags,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_write_reg,
    input  logic                  branch_taken,
    input  logic                  mem_wb_halt,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  stall_active,
    output logic                  halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    hcu_state_t             r_state;
    logic [STALL_CNT_W-1:0] r_cnt;
    logic [STALL_CNT_W-1:0] w_stall_n;
    logic                   w_stall;

    hazard_detect #(
        .REG_ADDR_W  (REG_ADDR_W),
        .STALL_CNT_W (STALL_CNT_W)
    ) u_detect (
        .if_id_rs          (if_id_rs),
        .if_id_rt          (if_id_rt),
        .if_id_uses_rt     (if_id_uses_rt),
        .if_id_is_store    (if_id_is_store),
        .if_id_branch      (if_id_branch),
        .if_id_cond_branch (if_id_cond_branch),
        .id_ex_rd          (id_ex_rd),
        .id_ex_write_reg   (id_ex_write_reg),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_sets_flags  (id_ex_sets_flags),
        .ex_mem_rd         (ex_mem_rd),
        .ex_mem_write_reg  (ex_mem_write_reg),
        .stall_n           (w_stall_n)
    );

    assign w_stall = (r_state == STALL) || ((r_state == IDLE) && (w_stall_n != '0));

    // The first stall cycle is served from IDLE; STALL covers the remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (mem_wb_halt) begin
            r_state <= HALTED;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_stall_n > STALL_CNT_W'(1)) begin
                        r_cnt   <= w_stall_n - STALL_CNT_W'(1);
                        r_state <= STALL;
                    end
                end
                STALL: begin
                    r_cnt <= r_cnt - STALL_CNT_W'(1);
                    if (r_cnt == STALL_CNT_W'(1)) r_state <= IDLE;
                end
                HALTED: r_state <= HALTED;
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Priority: reset, halt, stall, taken-branch flush.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        stall_active = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            pc_write = 1'b1;
        end else if ((r_state == HALTED) || mem_wb_halt) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            halted      = 1'b1;
        end else if (w_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            stall_active = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else if (r_state != HALTED) begin
            if (stall_active && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (if_id_flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module  : tb_hazard_control_unit
// Brief   : Directed plus randomized check of hazard_control_unit against a
//           rule-level model. Honours HAZARD_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic       if_id_uses_rt, if_id_is_store, if_id_branch, if_id_cond_branch;
    logic       id_ex_write_reg, id_ex_mem_read, id_ex_sets_flags, ex_mem_write_reg;
    logic       branch_taken, mem_wb_halt;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active, halted;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    hazard_control_unit #(
        .REG_ADDR_W  (4),
        .STALL_CNT_W (2)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .CNT_W       (CNT_W)
`endif
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .if_id_rs          (if_id_rs),
        .if_id_rt          (if_id_rt),
        .if_id_uses_rt     (if_id_uses_rt),
        .if_id_is_store    (if_id_is_store),
        .if_id_branch      (if_id_branch),
        .if_id_cond_branch (if_id_cond_branch),
        .id_ex_rd          (id_ex_rd),
        .id_ex_write_reg   (id_ex_write_reg),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_sets_flags  (id_ex_sets_flags),
        .ex_mem_rd         (ex_mem_rd),
        .ex_mem_write_reg  (ex_mem_write_reg),
        .branch_taken      (branch_taken),
        .mem_wb_halt       (mem_wb_halt),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .stall_active      (stall_active),
        .halted            (halted)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
`endif
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active, halted}
    logic [5:0] outs;
    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active, halted};

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: remaining stall cycles still owed, halt latch, perf totals.
    int         m_rem   = 0;
    bit         m_halt  = 1'b0;
    int         m_stall = 0;
    int         m_flush = 0;
    logic [5:0] m_e;

    function automatic bit mt(input bit we, input logic [3:0] rd, input logic [3:0] src);
        return we && (rd != 4'd0) && (rd == src);
    endfunction

    function automatic int req_n();
        int n = 0;
        if (id_ex_mem_read && (mt(id_ex_write_reg, id_ex_rd, if_id_rs) ||
            (if_id_uses_rt && !if_id_is_store && mt(id_ex_write_reg, id_ex_rd, if_id_rt))))
            n = (n > 1) ? n : 1;
        if (if_id_branch && mt(id_ex_write_reg, id_ex_rd, if_id_rs))   n = (n > 2) ? n : 2;
        if (if_id_branch && mt(ex_mem_write_reg, ex_mem_rd, if_id_rs)) n = (n > 1) ? n : 1;
        if (if_id_cond_branch && id_ex_sets_flags)                     n = (n > 1) ? n : 1;
        return n;
    endfunction

    function automatic logic [5:0] model_out();
        if (rst)                        return 6'b110000;
        if (m_halt || mem_wb_halt)      return 6'b000101;
        if ((m_rem > 0) || (req_n() > 0)) return 6'b000110;
        if (branch_taken)               return 6'b111000;
        return 6'b110000;
    endfunction

    always @(posedge clk) begin
        m_e = model_out();
        if (rst) begin
            m_rem = 0; m_halt = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_e[1] && (m_stall < CNT_MAX)) m_stall++;
            if (m_e[3] && (m_flush < CNT_MAX)) m_flush++;
            if (m_halt || mem_wb_halt) begin
                m_halt = 1'b1; m_rem = 0;
            end else if (m_rem > 0) begin
                m_rem--;
            end else if (req_n() > 0) begin
                m_rem = req_n() - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (outs !== model_out()) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got %b expected %b", $time, outs, model_out());
            end
`ifdef HAZARD_PERF_CNT_EN
            n_cmp++;
            if ((stall_cycles !== CNT_W'(m_stall)) || (flush_count !== CNT_W'(m_flush))) begin
                n_fail++;
                $display("FAIL perf t=%0t: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                         $time, stall_cycles, flush_count, m_stall, m_flush);
            end
`endif
        end
    end

    task automatic clr();
        if_id_rs = 4'd0; if_id_rt = 4'd0; id_ex_rd = 4'd0; ex_mem_rd = 4'd0;
        if_id_uses_rt = 1'b0; if_id_is_store = 1'b0; if_id_branch = 1'b0;
        if_id_cond_branch = 1'b0; id_ex_write_reg = 1'b0; id_ex_mem_read = 1'b0;
        id_ex_sets_flags = 1'b0; ex_mem_write_reg = 1'b0; branch_taken = 1'b0;
        mem_wb_halt = 1'b0;
    endtask

    // Check DUT and model against a hand-derived literal, then advance a cycle.
    task automatic lit(input string nm, input logic [5:0] exp);
        @(negedge clk);
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, outs, exp);
        end
        n_cmp++;
        if (model_out() !== exp) begin
            n_fail++;
            $display("FAIL model_%s: got %b expected %b", nm, model_out(), exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        lit("reset", 6'b110000);
        rst = 1'b0;

        // LW r3 in EX, ADD reading r3
        id_ex_rd = 4'd3; id_ex_write_reg = 1'b1; id_ex_mem_read = 1'b1; if_id_rs = 4'd3;
        lit("lu_stall", 6'b000110);
        clr();
        lit("lu_after", 6'b110000);

        // LW r3 in EX, SW with Rt=r3
        id_ex_rd = 4'd3; id_ex_write_reg = 1'b1; id_ex_mem_read = 1'b1;
        if_id_rs = 4'd5; if_id_rt = 4'd3; if_id_uses_rt = 1'b1; if_id_is_store = 1'b1;
        lit("sw_rt_nostall", 6'b110000);
        if_id_rs = 4'd3;
        lit("sw_rs_stall", 6'b000110);
        clr();
        lit("sw_after", 6'b110000);

        // ADD r4 in EX, BR r4: two stall cycles
        id_ex_rd = 4'd4; id_ex_write_reg = 1'b1; if_id_branch = 1'b1; if_id_rs = 4'd4;
        lit("br_ex_1", 6'b000110);
        clr();
        lit("br_ex_2", 6'b000110);
        lit("br_ex_done", 6'b110000);

        // r4 producer in MEM: one stall
        ex_mem_rd = 4'd4; ex_mem_write_reg = 1'b1; if_id_branch = 1'b1; if_id_rs = 4'd4;
        lit("br_mem", 6'b000110);
        clr();
        lit("br_mem_done", 6'b110000);

        // Flag wait, then taken flush
        if_id_cond_branch = 1'b1; id_ex_sets_flags = 1'b1; branch_taken = 1'b1;
        lit("flag_stall", 6'b000110);
        id_ex_sets_flags = 1'b0;
        lit("flag_flush", 6'b111000);
        clr();
        lit("flag_done", 6'b110000);

        // r0 writer never hazards
        id_ex_rd = 4'd0; id_ex_write_reg = 1'b1; id_ex_mem_read = 1'b1;
        if_id_branch = 1'b1; if_id_rs = 4'd0; if_id_rt = 4'd0; if_id_uses_rt = 1'b1;
        ex_mem_rd = 4'd0; ex_mem_write_reg = 1'b1;
        lit("r0_nostall", 6'b110000);
        clr();

        // Halt in the middle of a two-cycle stall
        id_ex_rd = 4'd4; id_ex_write_reg = 1'b1; if_id_branch = 1'b1; if_id_rs = 4'd4;
        lit("halt_pre_stall", 6'b000110);
        clr();
        mem_wb_halt = 1'b1;
        lit("halt_seen", 6'b000101);
        mem_wb_halt = 1'b0;
        lit("halted_held", 6'b000101);
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        n_cmp++;
        if ((stall_cycles !== 16'd7) || (flush_count !== 16'd1)) begin
            n_fail++;
            $display("FAIL perf_prehalt: got stall=%0d flush=%0d expected stall=7 flush=1",
                     stall_cycles, flush_count);
        end
        @(posedge clk);
        #1;
`endif
        lit("halted_held2", 6'b000101);
        rst = 1'b1;
        lit("rst_in_halt", 6'b110000);
        rst = 1'b0;
        lit("post_rst", 6'b110000);

        // Randomized phase, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            if_id_rs          = 4'($urandom_range(0, 3));
            if_id_rt          = 4'($urandom_range(0, 3));
            id_ex_rd          = 4'($urandom_range(0, 3));
            ex_mem_rd         = 4'($urandom_range(0, 3));
            if_id_uses_rt     = 1'($urandom_range(0, 1));
            if_id_is_store    = 1'($urandom_range(0, 1));
            if_id_branch      = ($urandom_range(0, 3) == 0);
            if_id_cond_branch = ($urandom_range(0, 3) == 0);
            id_ex_write_reg   = 1'($urandom_range(0, 1));
            id_ex_mem_read    = 1'($urandom_range(0, 1));
            id_ex_sets_flags  = 1'($urandom_range(0, 1));
            ex_mem_write_reg  = 1'($urandom_range(0, 1));
            branch_taken      = 1'($urandom_range(0, 1));
            mem_wb_halt       = ($urandom_range(0, 59) == 0);
            rst               = m_halt ? ($urandom_range(0, 5) == 0)
                                       : ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
